// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_pkg
// Purpose  : Shared widths, depth and controller state encoding for the
//            SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant; the search begins at i_start.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx
);

    logic [PTR_W-1:0] w_pos;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = PTR_W'((int'(i_start) + k) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin multi-requester front end for a single-port SRAM
//            macro, with optional zero-fill after reset.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*DATA_W-1:0] req_wmask,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      init_done,
    output logic                      sram_cen,
    output logic                      sram_gwen,
    output logic [DATA_W-1:0]         sram_wen,
    output logic [ADDR_W-1:0]         sram_a,
    output logic [DATA_W-1:0]         sram_d,
    input  logic [DATA_W-1:0]         sram_q
);

    localparam int                c_PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);
    localparam logic [ADDR_W-1:0]  c_FILL_LAST = ADDR_W'(DEPTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_fill_addr;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_run;
    logic                 w_hs;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [DATA_W-1:0]    w_sel_wmask;

    logic                 r_rd_pend1;
    logic                 r_rd_pend2;
    logic [c_PTR_W-1:0]   r_rd_id1;
    logic [c_PTR_W-1:0]   r_rd_id2;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;

    logic                 r_sram_cen;
    logic                 r_sram_gwen;
    logic [DATA_W-1:0]    r_sram_wen;
    logic [ADDR_W-1:0]    r_sram_a;
    logic [DATA_W-1:0]    r_sram_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_start     (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Gating with rst keeps ready and init_done low while reset is held,
    // even when the reset state is already RUN.
    assign w_run     = (r_state == ST_RUN) && !rst;
    assign req_ready = w_run ? w_grant : '0;
    assign init_done = w_run;
    assign w_hs      = |req_ready;
    assign w_ptr_nxt = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wmask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_wmask = req_wmask[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_fill_addr == c_FILL_LAST) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_addr <= '0;
            r_ptr       <= '0;
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_sram_a    <= '0;
            r_sram_d    <= '0;
        end else if (r_state == ST_INIT) begin
            r_fill_addr <= r_fill_addr + 1'b1;
            r_sram_cen  <= 1'b0;
            r_sram_gwen <= 1'b0;
            r_sram_wen  <= '0;
            r_sram_a    <= r_fill_addr;
            r_sram_d    <= '0;
        end else if (w_hs) begin
            r_ptr       <= w_ptr_nxt;
            r_sram_cen  <= 1'b0;
            r_sram_gwen <= ~w_sel_we;
            r_sram_wen  <= w_sel_we ? ~w_sel_wmask : '1;
            r_sram_a    <= w_sel_addr;
            r_sram_d    <= w_sel_wdata;
        end else begin
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
        end
    end

    // Two-stage read tag pipeline: macro captures at E+1, response at E+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend1  <= 1'b0;
            r_rd_pend2  <= 1'b0;
            r_rd_id1    <= '0;
            r_rd_id2    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rd_pend1  <= w_hs && !w_sel_we;
            r_rd_id1    <= w_grant_idx;
            r_rd_pend2  <= r_rd_pend1;
            r_rd_id2    <= r_rd_id1;
            r_rsp_valid <= r_rd_pend2 ? (NUM_REQ'(1) << r_rd_id2) : '0;
            if (r_rd_pend2) begin
                r_rsp_rdata <= sram_q;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign sram_cen  = r_sram_cen;
    assign sram_gwen = r_sram_gwen;
    assign sram_wen  = r_sram_wen;
    assign sram_a    = r_sram_a;
    assign sram_d    = r_sram_d;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed scoreboard bench for sram_arbiter with a behavioural
//            single-port macro model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [17:0] req_addr;
    logic [15:0] req_wdata, req_wmask;
    logic [7:0]  rsp_rdata;
    logic        init_done;
    logic        sram_cen, sram_gwen;
    logic [7:0]  sram_wen, sram_d, sram_q;
    logic [8:0]  sram_a;

    sram_arbiter #(
        .NUM_REQ        (2),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_seen = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Macro model: contents start as 0x5A so the zero-fill is observable.
    logic [7:0] mem [512];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'h5A;
            mem_ready = 1'b1;
        end
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            rsp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got valid=%b data=%h required no response",
                         cyc, rsp_valid, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_valid !== 2'(1 << e.id) || rsp_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp got valid=%b data=%h cyc=%0d required valid=%b data=%h cyc=%0d",
                             rsp_valid, rsp_rdata, cyc, 2'(1 << e.id), e.data, e.cyc);
                end
            end
        end
    end

    task automatic check_reset(input string name);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_rdata !== 8'h00 ||
            init_done !== 1'b0 || sram_cen !== 1'b1 || sram_gwen !== 1'b1 ||
            sram_wen !== 8'hFF || sram_a !== 9'h000 || sram_d !== 8'h00) begin
            errors++;
            $display("FAIL %s got ready=%b rsp=%b rdata=%h done=%b cen=%b gwen=%b wen=%h a=%h d=%h required 00 00 00 0 1 1 ff 000 00",
                     name, req_ready, rsp_valid, rsp_rdata, init_done, sram_cen, sram_gwen,
                     sram_wen, sram_a, sram_d);
        end
    endtask

    // Holds both requests during the fill to prove they are not accepted.
    task automatic fill_check(input int n);
        logic [1:0] exp_rdy;
        req_valid = 2'b11;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k == 511) ? 2'b01 : 2'b00;
            checks++;
            if (sram_a !== 9'(k) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
                sram_wen !== 8'h00 || sram_d !== 8'h00 || init_done !== (k == 511) ||
                req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fill[%0d] got a=%h cen=%b gwen=%b wen=%h d=%h done=%b ready=%b required a=%h 0 0 00 00 done=%b ready=%b",
                         k, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, init_done,
                         req_ready, 9'(k), (k == 511), exp_rdy);
            end
        end
        req_valid = 2'b00;
    endtask

    // Starts and returns at posedge+1; pushes the expected read response.
    task automatic do_req(input int i, input bit we, input logic [8:0] a,
                          input logic [7:0] d, input logic [7:0] m,
                          input bit track, input logic [7:0] exp_data);
        bit ok = 1'b0;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*9 +: 9]  = a;
        req_wdata[i*8 +: 8] = d;
        req_wmask[i*8 +: 8] = m;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if (req_ready[i]) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake req%0d addr=%h got no ready in 20 cycles required grant", i, a);
        end else begin
            if (!we && track) exp_q.push_back('{i, exp_data, cyc + 2});
            checks++;
            if (sram_cen !== 1'b0 || sram_gwen !== ~we || sram_a !== a ||
                sram_wen !== (we ? ~m : 8'hFF) || (we && sram_d !== d)) begin
                errors++;
                $display("FAIL pins req%0d got cen=%b gwen=%b wen=%h a=%h d=%h required 0 %b %h %h %h",
                         i, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, ~we,
                         (we ? ~m : 8'hFF), a, d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int saved;
    logic [1:0] exp_rdy;

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        check_reset("reset_state");
        req_valid = 2'b00;
        rst = 1'b0;
        fill_check(512);

        // Both requesters hold valid: grants must alternate 0,1,0,1,0,1.
        req_we = 2'b00;
        req_addr = {9'h0AB, 9'h1FF};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL alternate[%0d] got ready=%b required %b", k, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            exp_q.push_back('{k % 2, 8'h00, cyc + 2});
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 8'hFF || sram_a !== 9'h0AB) begin
            errors++;
            $display("FAIL idle_pins got cen=%b gwen=%b wen=%h a=%h required 1 1 ff 0ab",
                     sram_cen, sram_gwen, sram_wen, sram_a);
        end

        // Write then read the same address in the next cycle.
        do_req(0, 1'b1, 9'h010, 8'hA5, 8'hFF, 1'b0, 8'h00);
        do_req(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b1, 8'hA5);
        // Masked write merges into existing bits.
        do_req(0, 1'b1, 9'h020, 8'hFF, 8'hFF, 1'b0, 8'h00);
        do_req(0, 1'b1, 9'h020, 8'h00, 8'h0F, 1'b0, 8'h00);
        do_req(0, 1'b0, 9'h020, 8'h00, 8'h00, 1'b1, 8'hF0);
        // Zero mask still strobes the macro but changes nothing.
        do_req(1, 1'b1, 9'h010, 8'h33, 8'h00, 1'b0, 8'h00);
        do_req(1, 1'b0, 9'h010, 8'h00, 8'h00, 1'b1, 8'hA5);
        do_req(1, 1'b0, 9'h020, 8'h00, 8'h00, 1'b1, 8'hF0);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-fill restarts from address 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fill_check(101);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("reset_midfill");
        rst = 1'b0;
        fill_check(512);

        // Reset on the edge after a read handshake drops the response.
        saved = rsp_seen;
        do_req(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("reset_drop");
        rst = 1'b0;
        fill_check(512);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rsp_seen != saved) begin
            errors++;
            $display("FAIL dropped_rsp got %0d responses required 0", rsp_seen - saved);
        end

        do_req(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b1, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_rsp got %0d outstanding required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
